// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame widths, idle fill and serial-to-data bit ordering.
package spi_pkg;

    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned WORD_BITS = 32;

    // Shifted out when no response data is pending.
    localparam logic [31:0] IDLE_FILL = 32'hFFFF_FFFF;

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } state_e;

    // Serial bit k travels MSbit first within a byte, LSByte first within a word:
    // data bit = 8*(k/8) + 7 - (k%8).
    function automatic logic [4:0] ser_to_data_idx(input logic [4:0] k);
        return {k[4:3], ~k[2:0]};
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a third flop for edge detection.
module spi_sync #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q, sync_d;

    // Shift the pin value through the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[1:0], d_i};
    end

    // Synchronizer flops with synchronous reset to the pin's idle level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {3{ResetVal}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_target.sv
// Mode-0 SPI target: oversampled pins, byte/word frames, one-entry transmit holding register.
module spi_target
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fast,
    input  logic [31:0] dataTx,
    input  logic        txWr,
    output logic        txFull,
    output logic [31:0] dataRx,
    output logic        rxValid,
    output logic        busy,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO,
    output logic        MISOoe
);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;
    logic ss_level, ss_rise, ss_fall;

    spi_sync #(.ResetVal(1'b0)) u_sync_sclk (
        .clk_i   (clk),
        .rst_i   (rst),
        .d_i     (SCLK),
        .level_o (sclk_level_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync #(.ResetVal(1'b0)) u_sync_mosi (
        .clk_i   (clk),
        .rst_i   (rst),
        .d_i     (MOSI),
        .level_o (mosi_level),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    spi_sync #(.ResetVal(1'b1)) u_sync_ss (
        .clk_i   (clk),
        .rst_i   (rst),
        .d_i     (SS_n),
        .level_o (ss_level),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    state_e      state_q, state_d;
    logic        fast_q, fast_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] rx_shift_q, rx_shift_d;
    logic [31:0] tx_shift_q, tx_shift_d;
    logic [31:0] hold_q, hold_d;
    logic        tx_full_q, tx_full_d;
    logic [31:0] data_rx_q, data_rx_d;
    logic        rx_valid_q, rx_valid_d;
    logic        miso_q, miso_d;
    // After reset the SS_n synchronizer starts high; if the pin is already low that
    // would look like a falling edge. Frames are only accepted once SS_n has been
    // seen high with the synchronizer fully refilled from the pin.
    logic [1:0]  settle_q, settle_d;
    logic        armed_q, armed_d;

    logic        load;
    logic        last_bit;
    logic [31:0] rx_next;

    // Next-state logic for the frame FSM, shift registers and holding register.
    always_comb begin
        state_d    = state_q;
        fast_d     = fast_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        hold_d     = hold_q;
        tx_full_d  = tx_full_q;
        data_rx_d  = data_rx_q;
        rx_valid_d = 1'b0;
        miso_d     = miso_q;
        load       = 1'b0;

        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd3) & ss_level);

        last_bit = (bit_cnt_q == (fast_q ? 5'(WORD_BITS - 1) : 5'(BYTE_BITS - 1)));
        rx_next  = rx_shift_q;
        rx_next[ser_to_data_idx(bit_cnt_q)] = mosi_level;

        unique case (state_q)
            StIdle: begin
                if (armed_q && ss_fall) begin
                    state_d = StActive;
                    load    = 1'b1;
                end
            end
            StActive: begin
                if (ss_rise) begin
                    // Abort or normal end: partial receive data is dropped.
                    state_d   = StIdle;
                    bit_cnt_d = 5'd0;
                    miso_d    = 1'b1;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (last_bit) begin
                        bit_cnt_d  = 5'd0;
                        rx_valid_d = 1'b1;
                        data_rx_d  = fast_q ? rx_next
                                            : {{(WORD_BITS - BYTE_BITS){1'b0}},
                                               rx_next[BYTE_BITS-1:0]};
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else if (sclk_fall) begin
                    // A falling edge with the counter at 0 follows a completed frame.
                    if (bit_cnt_q == 5'd0) begin
                        load = 1'b1;
                    end else begin
                        miso_d = tx_shift_q[ser_to_data_idx(bit_cnt_q)];
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            fast_d     = fast;
            bit_cnt_d  = 5'd0;
            rx_shift_d = IDLE_FILL;
            if (tx_full_q) begin
                tx_shift_d = hold_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = IDLE_FILL;
            end
            miso_d = tx_shift_d[ser_to_data_idx(5'd0)];
        end

        // A write in the same cycle as a load lands after the load has taken the old value.
        if (txWr) begin
            hold_d    = dataTx;
            tx_full_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fast_q     <= 1'b0;
            bit_cnt_q  <= 5'd0;
            rx_shift_q <= IDLE_FILL;
            tx_shift_q <= IDLE_FILL;
            hold_q     <= 32'd0;
            tx_full_q  <= 1'b0;
            data_rx_q  <= 32'd0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b1;
            settle_q   <= 2'd0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fast_q     <= fast_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            hold_q     <= hold_d;
            tx_full_q  <= tx_full_d;
            data_rx_q  <= data_rx_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
        end
    end

    assign txFull  = tx_full_q;
    assign dataRx  = data_rx_q;
    assign rxValid = rx_valid_q;
    assign busy    = (state_q == StActive);
    assign MISO    = miso_q;
    assign MISOoe  = busy;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: directed scenarios plus randomized frames against a behavioural model.
module tb_spi_target;

    logic        clk = 1'b0;
    logic        rst, fast, txWr;
    logic [31:0] dataTx;
    logic        txFull;
    logic [31:0] dataRx;
    logic        rxValid, busy;
    logic        SCLK, MOSI, SS_n;
    logic        MISO, MISOoe;

    spi_target dut (
        .clk     (clk),
        .rst     (rst),
        .fast    (fast),
        .dataTx  (dataTx),
        .txWr    (txWr),
        .txFull  (txFull),
        .dataRx  (dataRx),
        .rxValid (rxValid),
        .busy    (busy),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .SS_n    (SS_n),
        .MISO    (MISO),
        .MISOoe  (MISOoe)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // rxValid monitor.
    int          rx_count = 0;
    logic [31:0] rx_last  = 32'd0;
    always @(negedge clk) begin
        if (rxValid) begin
            rx_count++;
            rx_last = dataRx;
        end
    end

    // Behavioural model: one-slot holding register and the last received frame.
    logic        model_full;
    logic [31:0] model_hold;
    logic [31:0] model_rx;

    task automatic m_load(output logic [31:0] sent);
        sent       = model_full ? model_hold : 32'hFFFF_FFFF;
        model_full = 1'b0;
    endtask

    task automatic m_write(input logic [31:0] v);
        model_hold = v;
        model_full = 1'b1;
    endtask

    // Serial position k carries byte k/8 of the word, most significant bit of that byte first.
    function automatic int data_bit(input int k);
        return 8 * (k / 8) + (7 - (k % 8));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [31:0] v);
        @(negedge clk);
        dataTx = v;
        txWr   = 1'b1;
        @(negedge clk);
        txWr = 1'b0;
        m_write(v);
    endtask

    task automatic ss_low(output logic [31:0] sent);
        @(negedge clk);
        SS_n = 1'b0;
        m_load(sent);
        clks(6);
    endtask

    // SS_n fall with a txWr landing in the same cycle the frame load acts.
    task automatic ss_low_wr(input logic [31:0] v, output logic [31:0] sent);
        @(negedge clk);
        SS_n = 1'b0;
        clks(2);
        dataTx = v;
        txWr   = 1'b1;
        m_load(sent);
        m_write(v);
        clks(1);
        txWr = 1'b0;
        clks(3);
    endtask

    task automatic ss_high();
        @(negedge clk);
        SS_n = 1'b1;
        clks(8);
    endtask

    // Controller at clk/16: serial positions k0..k1-1, MISO sampled at each SCLK rise.
    task automatic xfer(input int k0, input int k1, input logic [31:0] mo,
                        output logic [31:0] mi);
        mi = 32'd0;
        for (int k = k0; k < k1; k++) begin
            MOSI = mo[data_bit(k)];
            clks(8);
            mi[data_bit(k)] = MISO;
            SCLK = 1'b1;
            clks(8);
            SCLK = 1'b0;
        end
    endtask

    // One complete frame with SS_n already low; the final SCLK fall loads the next frame.
    task automatic body(input bit fm, input logic [31:0] mo, input logic [31:0] sent,
                        input string tag, input bit mid_wr, input logic [31:0] wr_val,
                        output logic [31:0] next_sent);
        int          n;
        int          rc0;
        logic [31:0] mask, mi_a, mi_b;
        n    = fm ? 32 : 8;
        mask = fm ? 32'hFFFF_FFFF : 32'h0000_00FF;
        rc0  = rx_count;
        xfer(0, 4, mo, mi_a);
        if (mid_wr) tx_write(wr_val);
        xfer(4, n, mo, mi_b);
        m_load(next_sent);
        clks(6);
        model_rx = mo & mask;
        check({tag, "_miso"}, mi_a | mi_b, sent & mask);
        check({tag, "_rxcnt"}, 32'(rx_count - rc0), 32'd1);
        check({tag, "_rxlast"}, rx_last, model_rx);
        check({tag, "_datarx"}, dataRx, model_rx);
    endtask

    initial begin
        logic [31:0] sent, nxt, nxt2, mi, pre_rx;
        int          rc0;
        bit          fm, wr_mid, b2b;

        rst = 1'b1; fast = 1'b0; txWr = 1'b0; dataTx = 32'd0;
        SCLK = 1'b0; MOSI = 1'b0; SS_n = 1'b1;
        model_full = 1'b0; model_hold = 32'd0; model_rx = 32'd0;
        clks(4);

        // Reset values.
        check("rst_txfull", {31'd0, txFull}, 32'd0);
        check("rst_datarx", dataRx, 32'd0);
        check("rst_rxvalid", {31'd0, rxValid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_miso", {31'd0, MISO}, 32'd1);
        check("rst_misooe", {31'd0, MISOoe}, 32'd0);
        rst = 1'b0;
        clks(8);

        // Byte mode.
        tx_write(32'h0000_00A5);
        check("byte_txfull_set", {31'd0, txFull}, {31'd0, model_full});
        fast = 1'b0;
        ss_low(sent);
        check("byte_txfull_clr", {31'd0, txFull}, {31'd0, model_full});
        check("byte_busy", {31'd0, MISOoe}, 32'd1);
        body(1'b0, 32'h0000_003C, sent, "byte", 1'b0, 32'd0, nxt);
        ss_high();

        // Word mode.
        tx_write(32'h1122_3344);
        fast = 1'b1;
        ss_low(sent);
        body(1'b1, 32'hDEAD_BEEF, sent, "word", 1'b0, 32'd0, nxt);
        ss_high();

        // Underrun, then back-to-back with a write during frame 1.
        fast = 1'b0;
        ss_low(sent);
        body(1'b0, 32'h0000_0096, sent, "b2b1", 1'b1, 32'h0000_005A, nxt);
        body(1'b0, 32'h0000_0071, nxt, "b2b2", 1'b0, 32'd0, nxt2);
        ss_high();

        // Abort after 5 bits, then a clean frame.
        pre_rx = model_rx;
        ss_low(sent);
        rc0 = rx_count;
        xfer(0, 5, 32'h0000_00C3, mi);
        ss_high();
        check("abort_rxcnt", 32'(rx_count - rc0), 32'd0);
        check("abort_datarx", dataRx, pre_rx);
        check("abort_misooe", {31'd0, MISOoe}, 32'd0);
        tx_write(32'h0000_0042);
        ss_low(sent);
        body(1'b0, 32'h0000_0018, sent, "post_abort", 1'b0, 32'd0, nxt);
        ss_high();

        // Write coincident with load while full: old value sent, new value pending.
        tx_write(32'h0000_0011);
        ss_low_wr(32'h0000_0022, sent);
        check("coinc_full_txfull", {31'd0, txFull}, 32'd1);
        body(1'b0, 32'h0000_00E7, sent, "coinc_full_f1", 1'b0, 32'd0, nxt);
        body(1'b0, 32'h0000_0055, nxt, "coinc_full_f2", 1'b0, 32'd0, nxt2);
        ss_high();

        // Write coincident with load while empty: idle fill sent, register now full.
        ss_low_wr(32'h0000_0033, sent);
        check("coinc_empty_txfull", {31'd0, txFull}, 32'd1);
        body(1'b0, 32'h0000_00AA, sent, "coinc_empty_f1", 1'b0, 32'd0, nxt);
        body(1'b0, 32'h0000_0001, nxt, "coinc_empty_f2", 1'b0, 32'd0, nxt2);
        ss_high();

        // Reset in the middle of a word frame.
        tx_write(32'hCAFE_F00D);
        fast = 1'b1;
        ss_low(sent);
        xfer(0, 12, 32'h1234_5678, mi);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_full = 1'b0;
        model_rx   = 32'd0;
        check("midrst_txfull", {31'd0, txFull}, 32'd0);
        check("midrst_datarx", dataRx, 32'd0);
        check("midrst_rxvalid", {31'd0, rxValid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_miso", {31'd0, MISO}, 32'd1);
        check("midrst_misooe", {31'd0, MISOoe}, 32'd0);
        rc0 = rx_count;
        xfer(12, 32, 32'h1234_5678, mi);
        clks(6);
        check("midrst_rxcnt", 32'(rx_count - rc0), 32'd0);
        check("midrst_idle", {31'd0, busy}, 32'd0);
        ss_high();
        ss_low(sent);
        body(1'b1, 32'h0BAD_F00D, sent, "post_rst", 1'b0, 32'd0, nxt);
        ss_high();

        // Randomized frames: mode, data, pending writes and back-to-back bursts.
        for (int i = 0; i < 12; i++) begin
            fm     = 1'($urandom_range(0, 1));
            wr_mid = 1'($urandom_range(0, 1));
            b2b    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) tx_write($urandom);
            fast = fm;
            ss_low(sent);
            body(fm, $urandom, sent, "rand_a", wr_mid, $urandom, nxt);
            if (b2b) begin
                body(fm, $urandom, nxt, "rand_b", 1'b0, 32'd0, nxt2);
            end
            ss_high();
            check("rand_txfull", {31'd0, txFull}, {31'd0, model_full});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

Mode-0 SPI target (peripheral end) for the SoC: lets an external SPI controller, such as another board running the same SPI controller block, exchange bytes or 32-bit words with a local CPU. It oversamples SCLK/MOSI/SS_n on the system clock and has a one-entry transmit holding register. Each completed frame is reported as a one-cycle strobe. Bit/byte ordering matches the SoC's SPI controller exactly.

## Interface
- No parameters; frame widths are fixed (8 and 32 bits).
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- fast  in  1  frame size: 0 = byte (8 bits), 1 = word (32 bits); sampled only at frame start.
- dataTx  in  32  response data for the next frame (byte mode uses [7:0]).
- txWr  in  1  one-cycle strobe: write dataTx into the holding register.
- txFull  out  1  holding register occupied (not yet consumed by a frame start).
- dataRx  out  32  last completed frame, zero-extended in byte mode; held until the next frame completes.
- rxValid  out  1  one-cycle strobe: dataRx updated.
- busy  out  1  SS_n asserted (synchronized).
- SCLK, MOSI, SS_n  in  1 each  SPI pins, asynchronous to clk.
- MISO  out  1  serial data out; MISOoe  out  1  output enable (= busy).

## Operation
- Reset values: txFull=0, dataRx=0, rxValid=0, busy=0, MISO=1, MISOoe=0, bit counter=0, shift registers all-ones.
- SCLK, MOSI and SS_n each pass through a 2-flop synchronizer. A third flop provides edge detection. SS_n synchronizer resets to 1, SCLK to 0.
- Mode 0: the target samples MOSI on the SCLK rising edge and updates MISO on the falling edge. Bits are MSbit first within a byte. In word mode bytes go LSByte first, so serial bit k (0..31) is data bit 8*(k/8)+7-(k%8).
- States: IDLE (SS_n high) and ACTIVE.
- Frame load:
  - Occurs on the SS_n falling edge, and also on the SCLK falling edge that follows the last bit of a frame while SS_n is still low (back-to-back frames).
  - Latch `fast`.
  - If txFull=1, load the holding register and clear txFull. Otherwise load all-ones.
  - Drive the first bit on MISO. Reset the bit counter to 0.
- Rising edge in ACTIVE: shift the sampled MOSI into the receive register and increment the bit counter.
- Completing bit 7 (byte) or bit 31 (word):
  - dataRx is assembled in the same byte order.
  - rxValid pulses for one cycle.
  - The bit counter returns to 0.
- Falling edge (not a frame load): present the next transmit bit.
- SS_n rise mid-frame: abort to IDLE. The partial frame is discarded, with no rxValid and no dataRx change. Consumed tx data is not restored. MISOoe drops.
- Holding register and txWr:
  - txWr while full overwrites the register; txFull stays 1.
  - txWr in the same cycle as a frame load with txFull=1: the load takes the old value, the register takes the new one, and txFull stays 1.
  - txWr in the same cycle as a frame load with txFull=0: the load sends all-ones, the register takes the new value, and txFull=1.
- rst mid-frame returns everything to reset values immediately. A frame still in progress on the pins is ignored until the next SS_n falling edge.

## Timing
- Edge latency: a pin edge acts on the 3rd clk rising edge after it reaches the pin (2 sync flops plus the edge register). Allow ±1 cycle for metastability resolution.
- rxValid is high in the cycle following the action of the final rising edge. dataRx is valid in that same cycle.
- MISO changes 3 clk cycles after the SCLK falling edge.
- External requirements:
  - SCLK high and low phases of at least 4 clk each (SCLK ≤ clk/8).
  - At least 4 clk from SS_n fall to the first SCLK rise.
  - MOSI stable for 3 clk around the SCLK rise.
- The controller's fast clk/3 mode is out of range. A controller on the same clock must use slow mode or a divided clock.

## Structure
- Shared package spi_pkg holds:
  - BYTE_BITS=8 and WORD_BITS=32.
  - The idle fill constant (all-ones).
  - A function mapping serial bit index to data bit index, shared with the SPI controller testbench.
- One sub-module, spi_sync: 2-flop synchronizer plus edge register, with outputs for level, rise and fall. It is instantiated for SCLK, MOSI and SS_n; only the level output is used for MOSI.
- The top level holds the state, bit counter, tx/rx shift registers and holding register. Expected size is about 180 lines.

## Test plan
- Byte mode:
  - Stimulus: txWr dataTx=0x000000A5. Controller at clk/16 sends 0x3C.
  - Required: MISO bits 1,0,1,0,0,1,0,1. rxValid once with dataRx=0x0000003C. txFull returns to 0 at SS_n fall.
- Word mode:
  - Stimulus: fast=1, dataTx=0x11223344. Controller sends 0xDEADBEEF in controller word order.
  - Required: serial MOSI bytes 0xEF,0xBE,0xAD,0xDE are assembled to dataRx=0xDEADBEEF. MISO carries 0x44,0x33,0x22,0x11 MSbit first.
- Underrun then back-to-back:
  - Stimulus: no txWr, then two byte frames with SS_n held low. txWr 0x5A occurs during frame 1.
  - Required: frame 1 MISO is 0xFF, frame 2 MISO is 0x5A. rxValid pulses twice.
- Abort:
  - Stimulus: SS_n rises after 5 bits.
  - Required: no rxValid, dataRx unchanged, MISOoe=0. The next full frame receives correctly.
- Simultaneous events:
  - txWr coincident with frame load, txFull=1: old data is sent and the new data is pending.
  - txWr coincident with frame load, txFull=0: 0xFF is sent and txFull=1.
- Reset:
  - Stimulus: rst pulse mid-word.
  - Required: all outputs at reset values next cycle. The remaining SCLK edges produce no rxValid until a new SS_n fall.
